uart_tx_scheduler: RTL and testbench
====================================

Name: uart_tx_scheduler

Overview:
- Sequences and shares the UART transmitter between two byte requesters.
- Arbitrates round-robin and loads the transmitter with a one-cycle enable pulse.
- Generates the baud tick (oBPS) and holds off further loads until the full frame plus a configurable idle gap has elapsed.
- Sits between the two byte sources and the transmitter's idata/iEN/iBPS inputs.

Parameters:
- CLK_DIV, 434: clock cycles per bit time (50 MHz / 115200). Legal range 2..65535; the baud counter is 16 bits.
- FRAME_BITS, 11: bit times per frame (start + 8 data + parity + stop). Legal range 1..15.

Ports:
- iClk  in  1  system clock, rising edge.
- iRst  in  1  reset, asynchronous, active-high.
- iData0  in  8  requester 0 byte.
- iValid0  in  1  requester 0 has a byte.
- oReady0  out  1  requester 0 byte accepted this cycle.
- iData1  in  8  requester 1 byte.
- iValid1  in  1  requester 1 has a byte.
- oReady1  out  1  requester 1 byte accepted this cycle.
- iGap  in  4  idle bit times inserted after each frame (0..15).
- oTxData  out  8  byte to transmitter idata.
- oTxEN  out  1  one-cycle load pulse to transmitter iEN.
- oBPS  out  1  one-cycle baud tick to transmitter iBPS.
- oBusy  out  1  frame or gap in progress.
- oGrant  out  1  index of the requester most recently granted.

Behaviour:
- Clock and reset: one clock, iClk. Reset is asynchronous and active-high on iRst.
- Reset values: state IDLE, oTxData 0, oTxEN 0, oBPS 0, oBusy 0, oGrant 0, priority pointer 0, all counters 0.
- Reset mid-frame: the frame is abandoned immediately with no pending load.
- Handshake: a transfer occurs on a cycle where iValidk and oReadyk are both 1. oReady0/oReady1 are combinational:
  - oReady0 = IDLE & iValid0 & (prio==0 | !iValid1)
  - oReady1 = IDLE & iValid1 & (prio==1 | !iValid0)
  - At most one is high in any cycle. oReady is never high outside IDLE.
- Arbitration is work-conserving: a lone valid is granted regardless of the pointer. On a grant to k, prio becomes !k and oGrant becomes k.
- States:
  - IDLE: on a transfer, register the granted iData into oTxData, sample iGap into an internal gap register, then go to LOAD.
  - LOAD (1 cycle): oTxEN=1; clear the baud counter and bit counter; go to FRAME.
  - FRAME: the baud counter counts 0..CLK_DIV-1. oBPS=1 on the cycle the count is CLK_DIV-1, then the count wraps to 0. The bit counter increments on each tick. On the FRAME_BITS-th tick, go to GAP if the sampled gap is nonzero, otherwise go to IDLE.
  - GAP: same tick generation. After gap-many ticks, go to IDLE.
- oBPS is 0 in IDLE and LOAD.
- oBusy is 1 in LOAD, FRAME and GAP.
- oTxData is held stable from the LOAD cycle until the next transfer.
- Changes on iGap after sampling have no effect on the current frame.
- Timing, with the transfer at cycle T:
  - oTxEN=1 at T+1.
  - First oBPS at T+1+CLK_DIV; subsequent ticks every CLK_DIV cycles.
  - With gap 0, the state is IDLE at T+2+FRAME_BITS*CLK_DIV, and a new transfer is possible that same cycle.
  - A gap adds gap*CLK_DIV cycles.
- Valid dropped before a grant: no transfer and no state change. Data is not required to stay valid across cycles.

Test Plan (CLK_DIV=4, FRAME_BITS=11, iGap=0 unless stated):
- Reset: iRst=1 -> all outputs 0, oReady0=oReady1=0 even with valids high. Release -> oReady0=1 that cycle if iValid0=1.
- Single byte: iValid0=1, iData0=0xA5 at T -> oReady0=1 at T; oTxEN=1 with oTxData=0xA5 at T+1; oBPS at T+5, T+9, ..., T+45 (11 pulses); oBusy=0 and IDLE at T+46.
- Contention: both valid continuously with 0x11/0x22 from reset -> grants 0x11 (oGrant 0), then 0x22 at T+46 (oGrant 1), then 0x11 at T+92.
- Lone requester: prio=0, only iValid1=1 with 0x3C -> oReady1=1 immediately; oTxData=0x3C next cycle.
- Gap: iGap=2 at the transfer, changed to 9 during the frame -> 13 oBPS pulses total; IDLE at T+54.
- Mid-frame reset: iRst pulsed at T+20 -> oBusy, oBPS and oTxEN go 0 asynchronously. After release with both valid -> requester 0 is granted first (prio reset to 0).

Source files
------------

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: round-robin arbiter feeding one UART transmitter, with baud tick and post-frame idle gap.
//   iClk/iRst              clock, async active-high reset
//   iData0/iValid0/oReady0 requester 0 byte handshake
//   iData1/iValid1/oReady1 requester 1 byte handshake
//   iGap                   idle bit times after each frame, sampled at the transfer
//   oTxData/oTxEN/oBPS     transmitter byte, load pulse, baud tick
//   oBusy/oGrant           frame or gap in progress, last granted requester
module uart_tx_scheduler #(
    parameter int CLK_DIV    = 434,
    parameter int FRAME_BITS = 11
) (
    input  logic       iClk,
    input  logic       iRst,
    input  logic [7:0] iData0,
    input  logic       iValid0,
    output logic       oReady0,
    input  logic [7:0] iData1,
    input  logic       iValid1,
    output logic       oReady1,
    input  logic [3:0] iGap,
    output logic [7:0] oTxData,
    output logic       oTxEN,
    output logic       oBPS,
    output logic       oBusy,
    output logic       oGrant
);
    typedef enum logic [1:0] {IDLE, LOAD, FRAME, GAP} state_t;
    localparam logic [15:0] BAUD_LAST = 16'(CLK_DIV - 1);
    localparam logic [3:0]  BIT_LAST  = 4'(FRAME_BITS - 1);
    state_t      state_q, state_d;
    logic [7:0]  data_q, data_d;
    logic [3:0]  gap_q, gap_d;
    logic [15:0] baud_q, baud_d;
    logic [3:0]  bit_q, bit_d;
    logic        prio_q, prio_d;
    logic        grant_q, grant_d;
    logic        txen_q, txen_d;
    logic        bps_q, bps_d;
    logic        busy_q, busy_d;
    logic        tick;
    // Ready is masked while reset is held so nothing is accepted during reset.
    assign oReady0 = !iRst && state_q == IDLE && iValid0 && (!prio_q || !iValid1);
    assign oReady1 = !iRst && state_q == IDLE && iValid1 && (prio_q || !iValid0);
    assign tick    = (state_q == FRAME || state_q == GAP) && baud_q == BAUD_LAST;
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        gap_d   = gap_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        prio_d  = prio_q;
        grant_d = grant_q;
        case (state_q)
            IDLE: if (oReady0 || oReady1) begin
                data_d  = oReady1 ? iData1 : iData0;
                gap_d   = iGap;
                grant_d = oReady1;
                prio_d  = !oReady1;
                state_d = LOAD;
            end
            LOAD: begin
                baud_d  = '0;
                bit_d   = '0;
                state_d = FRAME;
            end
            default: begin
                baud_d = tick ? '0 : baud_q + 16'd1;
                if (tick) begin
                    bit_d = bit_q + 4'd1;
                    if (state_q == FRAME && bit_q == BIT_LAST) begin
                        bit_d   = '0;
                        state_d = |gap_q ? GAP : IDLE;
                    end else if (state_q == GAP && bit_q == gap_q - 4'd1) begin
                        state_d = IDLE;
                    end
                end
            end
        endcase
        // Outputs are registered from next-state values so they line up with the state they describe.
        txen_d = state_d == LOAD;
        busy_d = state_d != IDLE;
        bps_d  = (state_d == FRAME || state_d == GAP) && baud_d == BAUD_LAST;
    end
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state_q <= IDLE;
            data_q  <= '0;
            gap_q   <= '0;
            baud_q  <= '0;
            bit_q   <= '0;
            prio_q  <= 1'b0;
            grant_q <= 1'b0;
            txen_q  <= 1'b0;
            bps_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            gap_q   <= gap_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            prio_q  <= prio_d;
            grant_q <= grant_d;
            txen_q  <= txen_d;
            bps_q   <= bps_d;
            busy_q  <= busy_d;
        end
    end
    assign oTxData = data_q;
    assign oTxEN   = txen_q;
    assign oBPS    = bps_q;
    assign oBusy   = busy_q;
    assign oGrant  = grant_q;
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb_uart_tx_scheduler: scoreboard bench for uart_tx_scheduler with CLK_DIV=4, FRAME_BITS=11.
module tb_uart_tx_scheduler;
    localparam int CD = 4;
    localparam int FB = 11;
    logic       clk, rst;
    logic [7:0] d0, d1, tx_data;
    logic       v0, v1, rdy0, rdy1, tx_en, bps, busy, grant;
    logic [3:0] gap;
    int         cyc = 0;
    int         n_cmp = 0;
    int         n_err = 0;
    int         m_t = -1000;
    int         m_free = 0;
    int         m_gap = 0;
    bit         m_prio = 0;
    logic       e0, e1, idle;
    int         dt;
    logic [8:0] q[$];
    logic [8:0] ex;
    uart_tx_scheduler #(.CLK_DIV(CD), .FRAME_BITS(FB)) dut (
        .iClk(clk), .iRst(rst),
        .iData0(d0), .iValid0(v0), .oReady0(rdy0),
        .iData1(d1), .iValid1(v1), .oReady1(rdy1),
        .iGap(gap), .oTxData(tx_data), .oTxEN(tx_en),
        .oBPS(bps), .oBusy(busy), .oGrant(grant)
    );
    initial clk = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask
    // Reference model: arbitration, frame timing and expected load contents, evaluated mid-cycle.
    always @(negedge clk) begin
        if (rst) begin
            chk("rst_out", {rdy0, rdy1, tx_data, tx_en, bps, busy, grant}, 0);
            m_prio = 0;
            m_free = 0;
            m_t    = -1000;
            m_gap  = 0;
            q.delete();
        end else begin
            idle = cyc >= m_free;
            e0   = idle && v0 && (!m_prio || !v1);
            e1   = idle && v1 && (m_prio || !v0);
            dt   = cyc - (m_t + 1);
            chk("ready0", rdy0, e0);
            chk("ready1", rdy1, e1);
            chk("txen", tx_en, dt == 0);
            chk("busy", busy, dt >= 0 && cyc < m_free);
            chk("bps", bps, dt > 0 && dt % CD == 0 && dt / CD <= FB + m_gap);
            if (tx_en) begin
                if (q.size() == 0) chk("pop_empty", 1, 0);
                else begin
                    ex = q.pop_front();
                    chk("txdata", tx_data, ex[7:0]);
                    chk("grant", grant, ex[8]);
                end
            end
            if (e0 || e1) begin
                q.push_back({e1, e1 ? d1 : d0});
                m_prio = !e1;
                m_t    = cyc;
                m_gap  = gap;
                m_free = cyc + 2 + (FB + gap) * CD;
            end
        end
    end
    task automatic wait_idle();
        int n = 0;
        while (cyc < m_free && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 200) chk("idle_timeout", 1, 0);
    endtask
    task automatic send_one(input bit k, input logic [7:0] b, input logic [3:0] g);
        wait_idle();
        if (k) begin
            v1 = 1;
            d1 = b;
        end else begin
            v0 = 1;
            d0 = b;
        end
        gap = g;
        @(posedge clk);
        #1;
        v0 = 0;
        v1 = 0;
    endtask
    initial begin
        rst = 1;
        v0  = 1;
        v1  = 1;
        d0  = 8'h11;
        d1  = 8'h22;
        gap = 0;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        repeat (140) @(posedge clk);
        #1;
        v0 = 0;
        v1 = 0;
        send_one(0, 8'hA5, 0);
        send_one(1, 8'h3C, 0);
        send_one(0, 8'h5A, 2);
        repeat (10) @(posedge clk);
        #1 gap = 9;
        send_one(1, 8'h77, 0);
        repeat (18) @(posedge clk);
        #2 rst = 1;
        #1 chk("async_rst", {busy, bps, tx_en}, 0);
        v0 = 1;
        v1 = 1;
        d0 = 8'h81;
        d1 = 8'h82;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        repeat (60) @(posedge clk);
        #1;
        v0 = 0;
        v1 = 0;
        wait_idle();
        repeat (2) @(negedge clk);
        chk("queue_empty", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
